ps2_rx_ctrl: RTL and testbench
==============================

# ps2_rx_ctrl

Receive-side controller for the PS/2 keyboard interface. It synchronises the raw PS/2 clock and data lines into the system clock domain and sequences an 11-bit frame: start bit, 8 data bits LSB first, odd parity, stop bit. It checks parity and framing, recovers from stalled frames with a timeout, and presents each received byte to the downstream decoder through a valid/ready handshake.

## Interface
- TIMEOUT_CYCLES, 50000: system clocks without a PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  reset, synchronous, active-high.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- rx_data  output  8  received byte, stable while rx_valid is high.
- rx_valid  output  1  byte available; held until accepted.
- parity_err  output  1  one-cycle pulse: frame dropped because parity was not odd.
- frame_err  output  1  one-cycle pulse: stop bit was 0, or the frame timed out.
- overrun  output  1  one-cycle pulse: a good frame completed while rx_valid was high; the new byte is dropped.
- busy  output  1  high in any state other than IDLE.

## Operation
- **Synchroniser:** ps2_clk and ps2_data each pass through 2 flops. A third flop on ps2_clk forms `fall` = previous synchronised value 1 and current synchronised value 0. The synchronised ps2_data is sampled only when `fall` is high.
- **States:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA and set bit_cnt=0. On `fall` with data=1, treat it as a glitch and stay in IDLE with no error.
  - DATA: on `fall`, shift right: shreg <= {data, shreg[7:1]}. Increment bit_cnt. After the 8th bit (bit_cnt==7 at the edge), go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, go to IDLE and evaluate the frame in this priority order:
    1. stop bit=0 → frame_err pulse.
    2. Otherwise, ^{shreg, parity}==0 → parity_err pulse.
    3. Otherwise, rx_valid=1 → overrun pulse.
    4. Otherwise, rx_data <= shreg and rx_valid <= 1.
- **Timeout:** a counter clears on every `fall` and in IDLE, and increments otherwise. When it reaches TIMEOUT_CYCLES-1 outside IDLE, the state goes to IDLE and frame_err pulses; the partial byte is discarded. The counter is wide enough to hold TIMEOUT_CYCLES-1.
- **Handshake:** rx_valid clears on a cycle with rx_valid && rx_ready. If acceptance and a new good frame completion coincide in the same cycle, the new byte loads, rx_valid stays 1, and no overrun is flagged.
- **Reset:**
  - state=IDLE, bit_cnt=0, shreg=0, rx_data=0x00, and timeout counter=0.
  - rx_valid, parity_err, frame_err, overrun and busy are all 0.
  - Synchroniser flops reset to 1 (idle bus level), so the first sampled value cannot create a false `fall`.
  - Reset mid-frame drops the frame with no error pulse.

## Timing
- `fall` is high for exactly 1 clk, 3 clk after the ps2_clk falling edge reaches the pin (2 sync flops + edge flop).
- rx_valid rises in the cycle after the clk in which `fall` marks the stop bit. The error and overrun pulses occur in that same cycle.
- busy rises in the cycle after the start-bit `fall` and falls together with the rx_valid rise.
- The PS/2 clock is 10–16.7 kHz, i.e. ≥3000 clk between edges at 50 MHz. No back-pressure reaches the PS/2 line; an unaccepted byte is lost via overrun.

## Structure
- Shared package `ps2_pkg`:
  - state enum (IDLE, DATA, PARITY, STOP);
  - PS2_DATA_BITS=8;
  - default TIMEOUT_CYCLES.
- Sub-module `ps2_sync_edge`: 2-flop synchroniser for both lines, plus the falling-edge detector. Outputs are data_s and fall. Reset value is 1.
- Everything else lives in the top-level state machine.

## Test plan
- **Clean frame:** send 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz, with rx_ready=1 on the first valid cycle. Expect rx_data=0x1C, rx_valid high for exactly 1 clk, and no error pulses.
- **Parity error:** send 0xF0 with parity bit 0 (correct parity is 1). Expect one parity_err pulse, rx_valid stays 0, and the state returns to IDLE.
- **Framing and timeout:**
  - Send 0x1C with stop bit 0 → one frame_err pulse.
  - Separately, stop ps2_clk after 4 data bits → frame_err fires TIMEOUT_CYCLES clk after the last edge, followed by a clean reception of 0x5A.
- **Overrun:** hold rx_ready=0, send 0x1C then 0x32. Expect rx_data to remain 0x1C and one overrun pulse. Then raise rx_ready → rx_valid clears the next cycle.
- **Glitch and reset:**
  - Inject a 1-clk-wide ps2_clk low pulse while data=1 → no state change.
  - Assert reset after 5 data bits of a frame → all outputs 0, state IDLE, and the next full frame 0x29 is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// The frame FSM state type is kept here so checkers and benches can decode the debug state.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS      = 8;
    localparam int PS2_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the raw PS/2 clock and data pins, plus a falling-edge strobe on the clock.
// All flops reset to 1 (idle bus level) so leaving reset cannot fake an edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);

    logic clk_m;
    logic clk_s;
    logic clk_d;
    logic data_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_m  <= 1'b1;
            clk_s  <= 1'b1;
            clk_d  <= 1'b1;
            data_m <= 1'b1;
            data_s <= 1'b1;
        end else begin
            clk_m  <= ps2_clk;
            clk_s  <= clk_m;
            clk_d  <= clk_s;
            data_m <= ps2_data;
            data_s <= data_m;
        end
    end

    assign fall = clk_d & ~clk_s;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: frames start/8 data/odd parity/stop bits, flags errors,
// aborts stalled frames, and hands bytes downstream on a valid/ready port.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     rx_ready,
    output logic [PS2_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy,
    output ps2_state_t               dbg_state
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic                     data_s;
    logic                     fall;
    ps2_state_t               state;
    logic [2:0]               bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic                     parity_bit;
    logic [TW-1:0]            to_cnt;
    logic                     timed_out;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    // A PS/2 edge always wins over the stall check in the same cycle.
    assign timed_out = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Handshake: rx_data is held stable while rx_valid is high; a byte transfers on any
    // cycle with rx_valid && rx_ready. A new byte may load in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (state == IDLE || fall)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);

            case (state)
                IDLE: begin
                    if (fall && !data_s) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shreg   <= {data_s, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(PS2_DATA_BITS - 1))
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    if (fall) begin
                        parity_bit <= data_s;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state <= IDLE;
                        if (!data_s)
                            frame_err <= 1'b1;
                        else if (^{shreg, parity_bit} == 1'b0)
                            parity_err <= 1'b1;
                        else if (rx_valid && !rx_ready)
                            overrun <= 1'b1;
                        else begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (timed_out) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_ps2_rx_ctrl;
    import ps2_pkg::*;

    localparam int TO   = 400;
    localparam int HALF = 40;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    ps2_state_t dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc      = 0;
    int pe_cnt   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int val_cnt  = 0;
    int fe_cyc   = 0;
    int last_fall_cyc = 0;
    int pe0, fe0, ov0, val0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_rx_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Monitor: counts pulses and collects accepted bytes at each active edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (parity_err) pe_cnt = pe_cnt + 1;
            if (frame_err) begin
                fe_cnt = fe_cnt + 1;
                fe_cyc = cyc;
            end
            if (overrun) ov_cnt = ov_cnt + 1;
            if (rx_valid) val_cnt = val_cnt + 1;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic snap();
        pe0  = pe_cnt;
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        val0 = val_cnt;
        got_q.delete();
    endtask

    // Sends the first nbits of a frame; odd parity unless par_ok is 0.
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok, input int nbits);
        logic [10:0] bits;
        logic        par;
        par  = par_ok ? ~(^d) : (^d);
        bits = {logic'(stop_ok), par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if ({parity_err, frame_err, overrun} !== 3'b000)
            $display("FAIL reset_pulses: got %b expected 000", {parity_err, frame_err, overrun}); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); else n_pass++;
    endtask

    task automatic test_clean_frame();
        rx_ready = 1'b1;
        snap();
        send_frame(8'h1C, 1, 1, 11);
        n_checks++; if (got_q.size() !== 1) $display("FAIL clean_count: got %0d expected 1", got_q.size());
        else begin
            n_pass++;
            n_checks++; if (got_q[0] !== 8'h1C) $display("FAIL clean_data: got %h expected 1c", got_q[0]); else n_pass++;
        end
        n_checks++; if (val_cnt - val0 !== 1) $display("FAIL clean_valid_width: got %0d expected 1", val_cnt - val0); else n_pass++;
        n_checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0) !== 0)
            $display("FAIL clean_errors: got %0d expected 0", (pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL clean_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_parity_err();
        snap();
        send_frame(8'hF0, 0, 1, 11);
        n_checks++; if (pe_cnt - pe0 !== 1) $display("FAIL parity_pulse: got %0d expected 1", pe_cnt - pe0); else n_pass++;
        n_checks++; if (val_cnt - val0 !== 0) $display("FAIL parity_valid: got %0d expected 0", val_cnt - val0); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL parity_state: got %0d expected %0d", dbg_state, IDLE); else n_pass++;
    endtask

    task automatic test_frame_err();
        snap();
        send_frame(8'h1C, 1, 0, 11);
        n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL stop_pulse: got %0d expected 1", fe_cnt - fe0); else n_pass++;
        n_checks++; if (val_cnt - val0 !== 0) $display("FAIL stop_valid: got %0d expected 0", val_cnt - val0); else n_pass++;
    endtask

    task automatic test_timeout();
        int lat;
        snap();
        send_frame(8'hA5, 1, 1, 5);
        for (int i = 0; i < TO + 100 && fe_cnt == fe0; i++) @(negedge clk);
        n_checks++; if (fe_cnt - fe0 !== 1) $display("FAIL timeout_pulse: got %0d expected 1", fe_cnt - fe0); else n_pass++;
        lat = fe_cyc - last_fall_cyc;
        n_checks++; if (lat < TO || lat > TO + 6) $display("FAIL timeout_latency: got %0d expected %0d..%0d", lat, TO, TO + 6); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL timeout_state: got %0d expected %0d", dbg_state, IDLE); else n_pass++;
        snap();
        send_frame(8'h5A, 1, 1, 11);
        n_checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A)
            $display("FAIL timeout_recover: got %0d bytes first %h expected 1 byte 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_overrun();
        @(negedge clk);
        rx_ready = 1'b0;
        snap();
        send_frame(8'h1C, 1, 1, 11);
        send_frame(8'h32, 1, 1, 11);
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL overrun_valid: got %b expected 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h1C) $display("FAIL overrun_data: got %h expected 1c", rx_data); else n_pass++;
        n_checks++; if (ov_cnt - ov0 !== 1) $display("FAIL overrun_pulse: got %0d expected 1", ov_cnt - ov0); else n_pass++;
        rx_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL overrun_accept: got %b expected 0", rx_valid); else n_pass++;
        n_checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h1C)
            $display("FAIL overrun_byte: got %0d bytes expected 1 byte 1c", got_q.size()); else n_pass++;
    endtask

    task automatic test_glitch();
        bit seen_busy;
        snap();
        seen_busy = 1'b0;
        @(negedge clk);
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        @(negedge clk);
        ps2_clk  = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        n_checks++; if (seen_busy !== 1'b0) $display("FAIL glitch_busy: got %b expected 0", seen_busy); else n_pass++;
        n_checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) !== 0) $display("FAIL glitch_errors: got %0d expected 0", (pe_cnt - pe0) + (fe_cnt - fe0)); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h77, 1, 1, 6);
        n_checks++; if (dbg_state !== DATA || busy !== 1'b1)
            $display("FAIL midframe_busy: got state %0d busy %b expected state %0d busy 1", dbg_state, busy, DATA); else n_pass++;
        snap();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if ({rx_valid, parity_err, frame_err, overrun, busy} !== 5'b0)
            $display("FAIL midreset_outputs: got %b expected 00000", {rx_valid, parity_err, frame_err, overrun, busy}); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL midreset_data: got %h expected 00", rx_data); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL midreset_state: got %0d expected %0d", dbg_state, IDLE); else n_pass++;
        send_frame(8'h29, 1, 1, 11);
        n_checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h29)
            $display("FAIL midreset_next: got %0d bytes expected 1 byte 29", got_q.size()); else n_pass++;
        n_checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) !== 0) $display("FAIL midreset_errors: got %0d expected 0", (pe_cnt - pe0) + (fe_cnt - fe0)); else n_pass++;
    endtask

    // Reference model: a frame is a good byte, a parity error or a stop error; consumer always ready.
    task automatic test_random();
        int exp_pe, exp_fe;
        logic [7:0] d;
        int kind;
        rx_ready = 1'b1;
        snap();
        exp_q.delete();
        exp_pe = 0;
        exp_fe = 0;
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            if (kind == 2) begin
                send_frame(d, 0, 1, 11);
                exp_pe++;
            end else if (kind == 3) begin
                send_frame(d, 1, 0, 11);
                exp_fe++;
            end else begin
                send_frame(d, 1, 1, 11);
                exp_q.push_back(d);
            end
        end
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL random_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (pe_cnt - pe0 !== exp_pe) $display("FAIL random_parity: got %0d expected %0d", pe_cnt - pe0, exp_pe); else n_pass++;
        n_checks++; if (fe_cnt - fe0 !== exp_fe) $display("FAIL random_frame: got %0d expected %0d", fe_cnt - fe0, exp_fe); else n_pass++;
        n_checks++; if (ov_cnt - ov0 !== 0) $display("FAIL random_overrun: got %0d expected 0", ov_cnt - ov0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_parity_err();
        test_frame_err();
        test_timeout();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
